// File: rtl/i2c_pwm_pkg.sv
// Shared definitions for the I2C-to-PWM register controller: FSM encoding,
// duty register width and the default slave address.
package i2c_pwm_pkg;

  localparam int         DUTY_W              = 16;
  localparam logic [6:0] DEFAULT_I2C_ADDRESS = 7'h42;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_PTR    = 3'd2,
    ST_DATA_H = 3'd3,
    ST_DATA_L = 3'd4,
    ST_IGNORE = 3'd5
  } state_t;

  // The controller counts as addressed once the address byte matched and until
  // the transfer ends or the pointer is rejected.
  function automatic logic state_is_selected(input state_t s);
    return (s == ST_PTR) || (s == ST_DATA_H) || (s == ST_DATA_L);
  endfunction

endpackage

// File: rtl/i2c_pwm_reg_controller_duty_shadow_bank.sv
// Per-channel shadow registers with dirty tracking; a commit copies every
// dirty shadow into the visible duty output in a single clock.
module duty_shadow_bank
  import i2c_pwm_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int PTR_W    = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       wr_en,
  input  logic [PTR_W-1:0]           wr_idx,
  input  logic [DUTY_W-1:0]          wr_data,
  input  logic                       commit_req,
  input  logic                       clear,
  output logic [DUTY_W*CHANNELS-1:0] duty,
  output logic                       commit
);

  logic [DUTY_W-1:0]   shadow_q [CHANNELS];
  logic [DUTY_W-1:0]   shadow_d [CHANNELS];
  logic [DUTY_W-1:0]   duty_q   [CHANNELS];
  logic [DUTY_W-1:0]   duty_d   [CHANNELS];
  logic [CHANNELS-1:0] dirty_q;
  logic [CHANNELS-1:0] dirty_d;
  logic                commit_q;
  logic                commit_d;

  always_comb begin
    shadow_d = shadow_q;
    duty_d   = duty_q;
    dirty_d  = dirty_q;
    commit_d = 1'b0;
    if (wr_en) begin
      for (int n = 0; n < CHANNELS; n++) begin
        if (wr_idx == PTR_W'(n)) begin
          shadow_d[n] = wr_data;
          dirty_d[n]  = 1'b1;
        end
      end
    end
    // A commit with nothing pending is silent: no pulse, outputs untouched.
    if (commit_req && (dirty_q != '0)) begin
      for (int n = 0; n < CHANNELS; n++) begin
        if (dirty_q[n]) duty_d[n] = shadow_q[n];
      end
      dirty_d  = '0;
      commit_d = 1'b1;
    end else if (clear) begin
      dirty_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int n = 0; n < CHANNELS; n++) begin
        shadow_q[n] <= '0;
        duty_q[n]   <= '0;
      end
      dirty_q  <= '0;
      commit_q <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      duty_q   <= duty_d;
      dirty_q  <= dirty_d;
      commit_q <= commit_d;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_duty_out
    assign duty[DUTY_W*g +: DUTY_W] = duty_q[g];
  end

  assign commit = commit_q;

endmodule

// File: rtl/i2c_pwm_reg_controller.sv
// Register-file front end for a PWM bank: decodes the serializer byte stream
// into pointer/duty writes and commits them atomically on STOP.
module i2c_pwm_reg_controller
  import i2c_pwm_pkg::*;
#(
  parameter logic [6:0] I2C_ADDRESS = DEFAULT_I2C_ADDRESS,
  parameter int         CHANNELS    = 4,
  parameter int         PTR_W       = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       wr,
  input  logic [7:0]                 write_data,
  output logic [DUTY_W*CHANNELS-1:0] duty,
  output logic                       commit,
  output logic                       selected,
  output logic                       error
);

  localparam logic [8:0]       CH_LIM   = 9'(CHANNELS);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(CHANNELS - 1);

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [7:0]        hbyte_q, hbyte_d;
  logic              error_q, error_d;

  logic              stop_ev;
  logic              wr_ev;
  logic              sh_wr_en;
  logic [DUTY_W-1:0] sh_wr_data;
  logic              commit_req;

  // start outranks stop, which outranks wr; losers in a cycle are dropped.
  assign stop_ev = stop & ~start;
  assign wr_ev   = wr & ~start & ~stop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      hbyte_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hbyte_q <= hbyte_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hbyte_d = hbyte_q;
    error_d = error_q;
    if (start) begin
      state_d = ST_ADDR;
      error_d = 1'b0;
    end else if (stop_ev) begin
      state_d = ST_IDLE;
    end else if (wr_ev) begin
      case (state_q)
        ST_ADDR: begin
          if ((write_data[7:1] == I2C_ADDRESS) && !write_data[0]) state_d = ST_PTR;
          else                                                    state_d = ST_IDLE;
        end
        ST_PTR: begin
          if ({1'b0, write_data} < CH_LIM) begin
            ptr_d   = write_data[PTR_W-1:0];
            state_d = ST_DATA_H;
          end else begin
            error_d = 1'b1;
            state_d = ST_IGNORE;
          end
        end
        ST_DATA_H: begin
          hbyte_d = write_data;
          state_d = ST_DATA_L;
        end
        ST_DATA_L: begin
          ptr_d   = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
          state_d = ST_DATA_H;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    selected   = state_is_selected(state_q);
    sh_wr_en   = wr_ev && (state_q == ST_DATA_L);
    sh_wr_data = {hbyte_q, write_data};
    commit_req = stop_ev;
  end

  // No abort path exists in this controller, so the bank's dirty clear is unused.
  duty_shadow_bank #(
    .CHANNELS (CHANNELS),
    .PTR_W    (PTR_W)
  ) u_bank (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en      (sh_wr_en),
    .wr_idx     (ptr_q),
    .wr_data    (sh_wr_data),
    .commit_req (commit_req),
    .clear      (1'b0),
    .duty       (duty),
    .commit     (commit)
  );

  assign error = error_q;

endmodule

// File: tb/tb_i2c_pwm_reg_controller.sv
// Bench for i2c_pwm_reg_controller: table-driven transactions plus hand-built
// corner sequences, with post-STOP expectations checked through a scoreboard.
module tb_i2c_pwm_reg_controller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, stop, wr;
  logic [7:0]  write_data;
  logic [63:0] duty;
  logic        commit, selected, error;

  i2c_pwm_reg_controller #(
    .I2C_ADDRESS (7'h42),
    .CHANNELS    (4),
    .PTR_W       (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .stop       (stop),
    .wr         (wr),
    .write_data (write_data),
    .duty       (duty),
    .commit     (commit),
    .selected   (selected),
    .error      (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] duty;
    logic        commit;
    logic        err;
  } exp_t;

  typedef struct packed {
    int          nbytes;
    logic [63:0] bytes;
    logic        exp_sel;
    logic [63:0] exp_duty;
    logic        exp_commit;
    logic        exp_err;
  } vec_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   commit_seen = 0;
  int   exp_commits = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic do_byte(input logic [7:0] b);
    @(negedge clk); wr = 1'b1; write_data = b;
    @(negedge clk); wr = 1'b0;
  endtask

  task automatic do_stop(input logic [63:0] ed, input logic ec, input logic ee);
    exp_t e;
    e.duty = ed; e.commit = ec; e.err = ee;
    sb.push_back(e);
    if (ec) exp_commits++;
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
  endtask

  // Scoreboard consumer: the cycle after an accepted STOP shows the result.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (stop === 1'b1 && start === 1'b0 && reset_n === 1'b1) begin
        @(negedge clk);
        if (sb.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL sb_underflow: got stop with empty queue, required a queued expectation");
        end else begin
          e = sb.pop_front();
          chk("duty_after_stop", duty, e.duty);
          chk("commit_after_stop", {63'd0, commit}, {63'd0, e.commit});
          chk("error_after_stop", {63'd0, error}, {63'd0, e.err});
        end
      end
    end
  end

  always @(negedge clk) if (commit === 1'b1) commit_seen++;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  localparam int NV = 8;
  vec_t vecs [NV];

  initial begin
    vec_t        v;
    logic [7:0]  b;
    logic [63:0] cur;

    vecs[0] = '{nbytes: 4, bytes: 64'h8401123400000000, exp_sel: 1'b1,
                exp_duty: 64'h0000_0000_1234_0000, exp_commit: 1'b1, exp_err: 1'b0};
    vecs[1] = '{nbytes: 6, bytes: 64'h8403AAAABBBB0000, exp_sel: 1'b1,
                exp_duty: 64'hAAAA_0000_1234_BBBB, exp_commit: 1'b1, exp_err: 1'b0};
    vecs[2] = '{nbytes: 4, bytes: 64'h8601555500000000, exp_sel: 1'b0,
                exp_duty: 64'hAAAA_0000_1234_BBBB, exp_commit: 1'b0, exp_err: 1'b0};
    vecs[3] = '{nbytes: 4, bytes: 64'h8501555500000000, exp_sel: 1'b0,
                exp_duty: 64'hAAAA_0000_1234_BBBB, exp_commit: 1'b0, exp_err: 1'b0};
    vecs[4] = '{nbytes: 4, bytes: 64'h8407999900000000, exp_sel: 1'b1,
                exp_duty: 64'hAAAA_0000_1234_BBBB, exp_commit: 1'b0, exp_err: 1'b1};
    vecs[5] = '{nbytes: 3, bytes: 64'h8402770000000000, exp_sel: 1'b1,
                exp_duty: 64'hAAAA_0000_1234_BBBB, exp_commit: 1'b0, exp_err: 1'b0};
    vecs[6] = '{nbytes: 5, bytes: 64'h8400112233000000, exp_sel: 1'b1,
                exp_duty: 64'hAAAA_0000_1234_1122, exp_commit: 1'b1, exp_err: 1'b0};
    vecs[7] = '{nbytes: 8, bytes: 64'h8402010203040506, exp_sel: 1'b1,
                exp_duty: 64'h0304_0102_1234_0506, exp_commit: 1'b1, exp_err: 1'b0};

    reset_n = 1'b0; start = 1'b0; stop = 1'b0; wr = 1'b0; write_data = 8'h00;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("reset_duty", duty, 64'd0);
    chk("reset_commit", {63'd0, commit}, 64'd0);
    chk("reset_selected", {63'd0, selected}, 64'd0);
    chk("reset_error", {63'd0, error}, 64'd0);

    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      do_start();
      for (int k = 0; k < v.nbytes; k++) begin
        b = v.bytes[63-8*k -: 8];
        do_byte(b);
        if (k == 0) chk($sformatf("vec%0d_selected", i), {63'd0, selected}, {63'd0, v.exp_sel});
      end
      do_stop(v.exp_duty, v.exp_commit, v.exp_err);
    end
    cur = 64'h0304_0102_1234_0506;

    // Repeated start: the first segment's pair commits only at the final STOP.
    do_start();
    do_byte(8'h84); do_byte(8'h00); do_byte(8'h44); do_byte(8'h55);
    do_start();
    do_byte(8'h84); do_byte(8'h02); do_byte(8'h33);
    chk("rs_no_early_commit", duty, cur);
    cur = 64'h0304_0102_1234_4455;
    do_stop(cur, 1'b1, 1'b0);

    // START and wr together: the byte is dropped, so 0x01 becomes the address.
    @(negedge clk); start = 1'b1; wr = 1'b1; write_data = 8'h84;
    @(negedge clk); start = 1'b0; wr = 1'b0;
    do_byte(8'h01);
    chk("start_wr_selected", {63'd0, selected}, 64'd0);
    do_byte(8'h12); do_byte(8'h34);
    do_stop(cur, 1'b0, 1'b0);

    // Bad pointer after a completed pair still commits that pair.
    do_start();
    do_byte(8'h84); do_byte(8'h01); do_byte(8'hDE); do_byte(8'hAD);
    do_start();
    do_byte(8'h84); do_byte(8'h09);
    chk("badptr_error", {63'd0, error}, 64'd1);
    chk("badptr_selected", {63'd0, selected}, 64'd0);
    do_byte(8'h55); do_byte(8'h66);
    cur = 64'h0304_0102_DEAD_4455;
    do_stop(cur, 1'b1, 1'b1);
    do_start();
    chk("start_clears_error", {63'd0, error}, 64'd0);
    do_stop(cur, 1'b0, 1'b0);

    // Reset in DATA_L discards everything, including the pending shadow.
    do_start();
    do_byte(8'h84); do_byte(8'h01); do_byte(8'h12); do_byte(8'h34);
    do_byte(8'h77);
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk);
    chk("midreset_duty", duty, 64'd0);
    chk("midreset_commit", {63'd0, commit}, 64'd0);
    chk("midreset_selected", {63'd0, selected}, 64'd0);
    reset_n = 1'b1;
    do_stop(64'd0, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    chk("commit_pulse_count", 64'(commit_seen), 64'(exp_commits));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
